// File: rtl/akuma_anim_controller.sv
// Per-frame action sequencer for the Akuma sprite: samples controls and hits on each
// frame_tick, steps the fighter state machine, and updates position, facing and animation.
module akuma_anim_controller #(
  parameter int X_START   = 100,
  parameter int X_MIN     = 0,
  parameter int X_MAX     = 500,
  parameter int FLOOR_Y   = 200,
  parameter int WALK_STEP = 2,
  parameter int PUSHBACK  = 4,
  parameter int JUMP_V0   = 12,
  parameter int FRAME_DIV = 6
) (
  input  logic       vga_clk,
  input  logic       reset_n,
  input  logic       frame_tick,
  input  logic       key_left,
  input  logic       key_right,
  input  logic       key_up,
  input  logic       key_punch,
  input  logic       key_kick,
  input  logic       hit,
  output logic [9:0] akuma_x,
  output logic [9:0] akuma_y,
  output logic [2:0] sprite_sel,
  output logic [1:0] anim_frame,
  output logic       facing_left,
  output logic       attack_active,
  output logic       busy
);

  typedef enum logic [2:0] {
    STAND   = 3'd0,
    WALK    = 3'd1,
    JUMP    = 3'd2,
    PUNCH   = 3'd3,
    KICK    = 3'd4,
    HITSTUN = 3'd5
  } state_t;

  localparam int DIV_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FRAME_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic signed [10:0] WALK_D  = 11'(WALK_STEP);
  localparam logic signed [10:0] PUSH_D  = 11'(PUSHBACK);
  localparam logic signed [10:0] XMIN_S  = 11'(X_MIN);
  localparam logic signed [10:0] XMAX_S  = 11'(X_MAX);
  localparam logic signed [10:0] FLOOR_S = 11'(FLOOR_Y);
  localparam logic signed [5:0]  VEL0    = 6'(JUMP_V0);

  state_t            state, state_nxt;
  logic [9:0]        x_q, x_nxt, y_q, y_nxt;
  logic signed [5:0] vel_q, vel_nxt, vel_use;
  logic [DIV_W-1:0]  div_q, div_nxt;
  logic [1:0]        anim_q, anim_nxt;
  logic              facing_q, facing_nxt, pending_q;
  logic              hp, div_wrap, jump_step;
  logic signed [10:0] dx, drift, push, x_calc, y_calc;

  // Everything advances only on frame_tick; between ticks only hit pulses are latched.
  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      state     <= STAND;
      x_q       <= 10'(X_START);
      y_q       <= 10'(FLOOR_Y);
      vel_q     <= '0;
      div_q     <= '0;
      anim_q    <= '0;
      facing_q  <= 1'b0;
      pending_q <= 1'b0;
    end else if (frame_tick) begin
      state     <= state_nxt;
      x_q       <= x_nxt;
      y_q       <= y_nxt;
      vel_q     <= vel_nxt;
      div_q     <= div_nxt;
      anim_q    <= anim_nxt;
      facing_q  <= facing_nxt;
      pending_q <= 1'b0;
    end else if (hit) begin
      pending_q <= 1'b1;
    end
  end

  always_comb begin
    hp         = pending_q | hit;
    div_wrap   = (div_q == DIV_LAST);
    drift      = '0;
    if (key_left && !key_right)      drift = -WALK_D;
    else if (key_right && !key_left) drift = WALK_D;
    push       = facing_q ? PUSH_D : -PUSH_D;
    state_nxt  = state;
    facing_nxt = facing_q;
    dx         = '0;
    jump_step  = 1'b0;
    vel_use    = vel_q;
    vel_nxt    = vel_q;
    y_nxt      = y_q;

    case (state)
      STAND, WALK: begin
        if (hp) begin
          state_nxt = HITSTUN;
          dx        = push;
        end else if (key_punch) begin
          state_nxt = PUNCH;
        end else if (key_kick) begin
          state_nxt = KICK;
        end else if (key_up) begin
          state_nxt = JUMP;
          jump_step = 1'b1;
          vel_use   = VEL0;
          dx        = drift;
        end else if (key_left ^ key_right) begin
          state_nxt  = WALK;
          facing_nxt = key_left;
          dx         = drift;
        end else begin
          state_nxt = STAND;
        end
      end
      PUNCH: begin
        if (hp) begin
          state_nxt = HITSTUN;
          dx        = push;
        end else if (div_wrap && anim_q == 2'd2) begin
          state_nxt = STAND;
        end
      end
      KICK: begin
        if (hp) begin
          state_nxt = HITSTUN;
          dx        = push;
        end else if (div_wrap && anim_q == 2'd3) begin
          state_nxt = STAND;
        end
      end
      HITSTUN: begin
        if (div_wrap && anim_q == 2'd1) state_nxt = STAND;
        else                            dx        = push;
      end
      JUMP: begin
        jump_step = 1'b1;
        dx        = drift;
      end
      default: state_nxt = STAND;
    endcase

    // The take-off tick is the first ballistic step, using the launch velocity.
    y_calc = $signed({1'b0, y_q}) - $signed({{5{vel_use[5]}}, vel_use});
    if (jump_step) begin
      vel_nxt = vel_use - 6'sd1;
      if (y_calc >= FLOOR_S && vel_use[5]) begin
        y_nxt     = 10'(FLOOR_Y);
        vel_nxt   = '0;
        state_nxt = STAND;
      end else begin
        y_nxt = y_calc[9:0];
      end
    end

    x_calc = $signed({1'b0, x_q}) + dx;
    if (x_calc < XMIN_S)      x_nxt = 10'(X_MIN);
    else if (x_calc > XMAX_S) x_nxt = 10'(X_MAX);
    else                      x_nxt = x_calc[9:0];

    if (state_nxt != state) begin
      div_nxt  = '0;
      anim_nxt = '0;
    end else if (div_wrap) begin
      div_nxt  = '0;
      anim_nxt = (state == JUMP && anim_q == 2'd3) ? anim_q : anim_q + 2'd1;
    end else begin
      div_nxt  = div_q + DIV_ONE;
      anim_nxt = anim_q;
    end
  end

  always_comb begin
    akuma_x       = x_q;
    akuma_y       = y_q;
    sprite_sel    = state;
    anim_frame    = anim_q;
    facing_left   = facing_q;
    attack_active = ((state == PUNCH) && (anim_q == 2'd1)) ||
                    ((state == KICK)  && (anim_q == 2'd2));
    busy          = (state == JUMP) || (state == PUNCH) ||
                    (state == KICK) || (state == HITSTUN);
  end

endmodule
